// File: rtl/instr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instr_sequencer_pkg
// Shared definitions for the instruction sequencer: default widths/depths and
// the sequencer state encoding.
// -----------------------------------------------------------------------------
package instr_sequencer_pkg;

  localparam int PC_W_DEF      = 10;  // program counter width
  localparam int IW_DEF        = 9;   // instruction width
  localparam int LUT_DEPTH_DEF = 16;  // jump-target entries
  localparam int LUT_AW        = 4;   // jump-target index width

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM_WAIT,
    HALT
  } state_t;

endpackage

// File: rtl/jump_lut.sv
// -----------------------------------------------------------------------------
// jump_lut
// Jump-target table: DEPTH registers of PC_W bits, one synchronous write port
// and one combinational read port. A read of an entry being written in the
// same cycle returns the old contents.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset, clears every entry
//   we     : write enable
//   waddr  : write index
//   wdata  : write data
//   raddr  : read index
//   rdata  : read data (combinational)
// -----------------------------------------------------------------------------
module jump_lut
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = LUT_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);

  logic [PC_W-1:0] entries_q [DEPTH];

  // NOTE: the table is small and built from flops, so it is cleared on reset
  // like any other state; a RAM macro would need an explicit init sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (we && (int'(waddr) < DEPTH)) begin
      entries_q[waddr] <= wdata;
    end
  end

  // Indices beyond the populated depth read as zero.
  assign rdata = (int'(raddr) < DEPTH) ? entries_q[raddr] : '0;

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle instruction sequencer: fetches from instruction memory, hands the
// instruction register to an external decoder, and steps the PC by +1, by a
// table-driven jump, or after a data-memory handshake. Baseline CPI is 2
// (FETCH, EXEC); memory instructions stretch with MEM_WAIT.
//
// Ports
//   clk, rst_n          : clock; synchronous active-low reset
//   start               : begin execution at PC 0 (honoured in IDLE/HALT)
//   done                : program halted
//   pc                  : instruction memory address
//   imem_data           : instruction memory read data
//   ir, instr_valid     : instruction register; high in the EXEC cycle
//   is_halt/is_mem/is_jump, jump_idx, branch_taken : decoder feedback
//   mem_req, mem_ack    : data-memory handshake
//   lut_we/lut_addr/lut_data : jump-target table write (IDLE/HALT only)
// -----------------------------------------------------------------------------
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int IW        = IW_DEF,
  parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic [PC_W-1:0]   pc,
  input  logic [IW-1:0]     imem_data,
  output logic [IW-1:0]     ir,
  output logic              instr_valid,
  input  logic              is_halt,
  input  logic              is_mem,
  input  logic              is_jump,
  input  logic [LUT_AW-1:0] jump_idx,
  input  logic              branch_taken,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_addr,
  input  logic [PC_W-1:0]   lut_data
);

  state_t          state;
  logic            lut_wr_en;
  logic [PC_W-1:0] jump_target;

  // The table may only change while no program is running.
  assign lut_wr_en = lut_we && ((state == IDLE) || (state == HALT));

  jump_lut #(
    .PC_W  (PC_W),
    .DEPTH (LUT_DEPTH)
  ) u_jump_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_wr_en),
    .waddr (lut_addr),
    .wdata (lut_data),
    .raddr (jump_idx),
    .rdata (jump_target)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      instr_valid <= 1'b0;
      mem_req     <= 1'b0;
      done        <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          pc <= '0;
          if (start) state <= FETCH;
        end

        FETCH: begin
          ir          <= imem_data;
          instr_valid <= 1'b1;
          state       <= EXEC;
        end

        EXEC: begin
          // Halt wins over memory, memory over jump.
          if (is_halt) begin
            done  <= 1'b1;
            state <= HALT;
          end else if (is_mem) begin
            mem_req <= 1'b1;
            state   <= MEM_WAIT;
          end else if (is_jump && branch_taken) begin
            pc    <= jump_target;
            state <= FETCH;
          end else begin
            pc    <= pc + PC_W'(1);
            state <= FETCH;
          end
        end

        MEM_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            pc      <= pc + PC_W'(1);
            state   <= FETCH;
          end
        end

        HALT: begin
          if (start) begin
            pc    <= '0;
            done  <= 1'b0;
            state <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
